stoch_avg_mat_div: RTL and testbench



---
 rtl/stoch_avg_mat_div.sv | 104 ++++++++++
 tb/tb_stoch_avg_mat_div.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stoch_avg_mat_div.sv
// Stochastic averaging matrix with a runtime divisor.
// Each element adds up NUM_POPS input bitstreams and divides the sum by D
// using an accumulate-and-subtract remainder counter. The output is one
// bitstream per element.
module stoch_avg_mat_div #(
   parameter int NUM_POPS = 2,
   parameter int NUM_ROWS = 3,
   parameter int NUM_COLS = 3,
   localparam int PW = $clog2(NUM_POPS + 1),
   localparam int AW = $clog2(2 * NUM_POPS)
) (
   input  logic                                             CLK,
   input  logic                                             RST,
   input  logic                                             EN,
   input  logic                                             CLR,
   input  logic [PW-1:0]                                    DIV,
   input  logic [NUM_ROWS-1:0][NUM_COLS-1:0][NUM_POPS-1:0] A,
   output logic [NUM_ROWS-1:0][NUM_COLS-1:0]                Y,
   output logic                                             OVF
);

   // The sum ACC + P needs one extra bit so the compare against D cannot wrap.
   localparam int SW = AW + 1;

   logic [NUM_ROWS-1:0][NUM_COLS-1:0][PW-1:0] p_q, p_d;
   logic [NUM_ROWS-1:0][NUM_COLS-1:0][AW-1:0] acc_q, acc_d;
   logic [NUM_ROWS-1:0][NUM_COLS-1:0]         y_q, y_d;
   logic                                      ovf_q, ovf_d;

   logic [PW-1:0] d_eff;
   logic [SW-1:0] d_ext;

   // A divisor of zero selects the full population count as the divisor.
   assign d_eff = (DIV == '0) ? PW'(NUM_POPS) : DIV;
   assign d_ext = SW'(d_eff);

   // Stage 1: popcount of each element's input bundle.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      p_d = '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         for (int j = 0; j < NUM_COLS; j++) begin
            for (int k = 0; k < NUM_POPS; k++) begin
               p_d[i][j] = p_d[i][j] + PW'(A[i][j][k]);
            end
         end
      end
   end

   // Stage 2: accumulate, emit a one when the sum reaches D, clamp the remainder.
   always_comb begin : stage2_comb
      logic [SW-1:0] sum;
      logic [SW-1:0] rem;
      sum   = '0;
      rem   = '0;
      acc_d = acc_q;
      y_d   = y_q;
      ovf_d = ovf_q;
      for (int i = 0; i < NUM_ROWS; i++) begin
         for (int j = 0; j < NUM_COLS; j++) begin
            sum = SW'(acc_q[i][j]) + SW'(p_q[i][j]);
            if (sum >= d_ext) begin
               y_d[i][j] = 1'b1;
               rem       = sum - d_ext;
            end else begin
               y_d[i][j] = 1'b0;
               rem       = sum;
            end
            // The remainder can only reach D when D is below NUM_POPS. Pin it to
            // D-1 so ACC always stays below D, and flag that a clamp happened.
            if (rem >= d_ext) begin
               acc_d[i][j] = AW'(d_ext - SW'(1));
               ovf_d       = 1'b1;
            end else begin
               acc_d[i][j] = AW'(rem);
            end
         end
      end
   end

   // State registers: reset and clear win over enable, and EN low freezes everything.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the values from before the edge.
      if (RST || CLR) begin
         // NOTE: the per-element registers are plain flops, not a RAM, so the
         // whole array can be cleared in one cycle.
         p_q   <= '0;
         acc_q <= '0;
         y_q   <= '0;
         ovf_q <= 1'b0;
      end else if (EN) begin
         p_q   <= p_d;
         acc_q <= acc_d;
         y_q   <= y_d;
         ovf_q <= ovf_d;
      end
   end

   assign Y   = y_q;
   assign OVF = ovf_q;

endmodule

// File: tb/tb_stoch_avg_mat_div.sv
// Testbench for stoch_avg_mat_div. It exercises three instances:
// NUM_POPS=2 (directed), NUM_POPS=4 (randomised vs. model), NUM_POPS=1.
module tb_stoch_avg_mat_div;

   logic clk;
   logic rst;

   // NUM_POPS=2, 3x3
   logic                  en2, clr2, ovf2;
   logic [1:0]            div2;
   logic [2:0][2:0][1:0]  a2;
   logic [2:0][2:0]       y2;

   // NUM_POPS=4, 3x3
   logic                  en4, clr4, ovf4;
   logic [2:0]            div4;
   logic [2:0][2:0][3:0]  a4;
   logic [2:0][2:0]       y4;

   // NUM_POPS=1, 1x2
   logic                  en1, clr1, ovf1;
   logic [0:0]            div1;
   logic [0:0][1:0][0:0]  a1;
   logic [0:0][1:0]       y1;

   int total;
   int bad;

   stoch_avg_mat_div #(.NUM_POPS(2), .NUM_ROWS(3), .NUM_COLS(3)) u_dut2 (
      .CLK(clk), .RST(rst), .EN(en2), .CLR(clr2), .DIV(div2), .A(a2), .Y(y2), .OVF(ovf2)
   );

   stoch_avg_mat_div #(.NUM_POPS(4), .NUM_ROWS(3), .NUM_COLS(3)) u_dut4 (
      .CLK(clk), .RST(rst), .EN(en4), .CLR(clr4), .DIV(div4), .A(a4), .Y(y4), .OVF(ovf4)
   );

   stoch_avg_mat_div #(.NUM_POPS(1), .NUM_ROWS(1), .NUM_COLS(2)) u_dut1 (
      .CLK(clk), .RST(rst), .EN(en1), .CLR(clr1), .DIV(div1), .A(a1), .Y(y1), .OVF(ovf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the run never reaches its summary.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Advance one rising edge and step away from it before sampling.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear2;
      clr2 = 1'b1;
      en2  = 1'b1;
      tick();
      clr2 = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      en2 = 1'b1; en4 = 1'b1; en1 = 1'b1;
      div2 = 2'd2; div4 = 3'd3; div1 = 1'b1;
      for (int c = 0; c < 3; c++) begin
         a2 = 18'($urandom());
         a4 = 36'({$urandom(), $urandom()});
         a1 = 2'($urandom());
         tick();
         total++;
         if ({y2, y4, y1} !== 20'd0) begin
            bad++;
            $display("FAIL reset_y cycle=%0d got=%h exp=0", c, {y2, y4, y1});
         end
         total++;
         if ({ovf2, ovf4, ovf1} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ovf cycle=%0d got=%b exp=000", c, {ovf2, ovf4, ovf1});
         end
      end
      rst = 1'b0;
      a2 = 18'($urandom());
      a4 = 36'({$urandom(), $urandom()});
      a1 = 2'($urandom());
      tick();
      total++;
      if ({y2, y4, y1, ovf2, ovf4, ovf1} !== 23'd0) begin
         bad++;
         $display("FAIL reset_release got=%h exp=0", {y2, y4, y1, ovf2, ovf4, ovf1});
      end
   endtask

   task automatic test_full_rate;
      clear2();
      div2 = 2'd2;
      a2 = '0;
      a2[0][0] = 2'b11;
      for (int k = 1; k <= 10; k++) begin
         logic [8:0] exp_y;
         tick();
         exp_y = (k >= 2) ? 9'h001 : 9'h000;
         total++;
         if (y2 !== exp_y || ovf2 !== 1'b0) begin
            bad++;
            $display("FAIL full_rate edge=%0d got y=%h ovf=%b exp y=%h ovf=0", k, y2, ovf2, exp_y);
         end
      end
   endtask

   task automatic test_half_rate(input logic [1:0] dv);
      int ones;
      ones = 0;
      clear2();
      div2 = dv;
      a2 = '0;
      a2[1][1] = 2'b01;
      for (int k = 1; k <= 1001; k++) begin
         logic [8:0] exp_y;
         tick();
         exp_y = (k >= 2 && (k % 2) == 1) ? 9'h010 : 9'h000;
         if (k >= 2 && y2[1][1] === 1'b1) ones++;
         total++;
         if (y2 !== exp_y || ovf2 !== 1'b0) begin
            bad++;
            $display("FAIL half_rate div=%0d edge=%0d got y=%h ovf=%b exp y=%h ovf=0",
                     dv, k, y2, ovf2, exp_y);
         end
      end
      total++;
      if (ones < 490 || ones > 510) begin
         bad++;
         $display("FAIL half_rate_mean div=%0d got ones=%0d exp 490..510 of 1000", dv, ones);
      end
   endtask

   task automatic test_overflow;
      clear2();
      div2 = 2'd1;
      a2 = '0;
      a2[0][0] = 2'b11;
      tick();
      total++;
      if (y2 !== 9'h000 || ovf2 !== 1'b0) begin
         bad++;
         $display("FAIL ovf_first got y=%h ovf=%b exp y=000 ovf=0", y2, ovf2);
      end
      tick();
      total++;
      if (y2 !== 9'h001 || ovf2 !== 1'b1) begin
         bad++;
         $display("FAIL ovf_clamp got y=%h ovf=%b exp y=001 ovf=1", y2, ovf2);
      end
      div2 = 2'd2;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++;
         if (y2 !== 9'h001 || ovf2 !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky edge=%0d got y=%h ovf=%b exp y=001 ovf=1", k, y2, ovf2);
         end
      end
      // Clear while A is active: it must not be captured into P.
      clr2 = 1'b1;
      tick();
      total++;
      if (y2 !== 9'h000 || ovf2 !== 1'b0) begin
         bad++;
         $display("FAIL clr_now got y=%h ovf=%b exp y=000 ovf=0", y2, ovf2);
      end
      clr2 = 1'b0;
      tick();
      total++;
      if (y2 !== 9'h000) begin
         bad++;
         $display("FAIL clr_first_edge got y=%h exp y=000", y2);
      end
      tick();
      total++;
      if (y2 !== 9'h001 || ovf2 !== 1'b0) begin
         bad++;
         $display("FAIL clr_second_edge got y=%h ovf=%b exp y=001 ovf=0", y2, ovf2);
      end
   endtask

   task automatic test_stall;
      clear2();
      div2 = 2'd2;
      a2 = '0;
      a2[1][1] = 2'b01;
      for (int k = 1; k <= 6; k++) begin
         logic [8:0] exp_y;
         tick();
         exp_y = (k >= 3 && (k % 2) == 1) ? 9'h010 : 9'h000;
         total++;
         if (y2 !== exp_y) begin
            bad++;
            $display("FAIL stall_pre edge=%0d got y=%h exp y=%h", k, y2, exp_y);
         end
      end
      // Frozen: inputs that would change the result are presented and must be ignored.
      en2 = 1'b0;
      a2[1][1] = 2'b11;
      div2 = 2'd1;
      for (int k = 0; k < 5; k++) begin
         tick();
         total++;
         if (y2 !== 9'h000 || ovf2 !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold edge=%0d got y=%h ovf=%b exp y=000 ovf=0", k, y2, ovf2);
         end
      end
      en2 = 1'b1;
      a2[1][1] = 2'b01;
      div2 = 2'd2;
      for (int m = 1; m <= 6; m++) begin
         logic [8:0] exp_y;
         tick();
         exp_y = ((m % 2) == 1) ? 9'h010 : 9'h000;
         total++;
         if (y2 !== exp_y || ovf2 !== 1'b0) begin
            bad++;
            $display("FAIL stall_resume edge=%0d got y=%h ovf=%b exp y=%h ovf=0", m, y2, ovf2, exp_y);
         end
      end
   endtask

   // With a single stream the divisor is always 1, so Y is A delayed by two enabled edges.
   task automatic test_one_pop;
      logic [1:0] p_m;
      logic [1:0] y_m;
      clr1 = 1'b1;
      en1  = 1'b1;
      tick();
      clr1 = 1'b0;
      p_m = '0;
      y_m = '0;
      for (int k = 0; k < 200; k++) begin
         en1  = ($urandom_range(0, 3) != 0);
         a1   = 2'($urandom());
         div1 = 1'($urandom());
         if (en1) begin
            y_m = p_m;
            p_m = a1;
         end
         tick();
         total++;
         if (y1 !== y_m || ovf1 !== 1'b0) begin
            bad++;
            $display("FAIL one_pop cycle=%0d got y=%b ovf=%b exp y=%b ovf=0", k, y1, ovf1, y_m);
         end
      end
   endtask

   // Behavioural model: each element keeps a pending count and a remainder,
   // and emits a one for every whole D it collects.
   task automatic test_random;
      int  mp[3][3];
      int  macc[3][3];
      bit  my[3][3];
      bit  movf;
      int  d, s, rr;
      logic [8:0] exp_y;
      movf = 1'b0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            mp[r][c] = 0; macc[r][c] = 0; my[r][c] = 1'b0;
         end
      end
      for (int k = 0; k < 10000; k++) begin
         en4  = ($urandom_range(0, 99) < 85);
         clr4 = (k == 0) || ($urandom_range(0, 199) == 0);
         div4 = 3'($urandom_range(1, 4));
         if ($urandom_range(0, 19) == 0) div4 = 3'd0;
         a4   = 36'({$urandom(), $urandom()});
         if (clr4) begin
            movf = 1'b0;
            for (int r = 0; r < 3; r++) begin
               for (int c = 0; c < 3; c++) begin
                  mp[r][c] = 0; macc[r][c] = 0; my[r][c] = 1'b0;
               end
            end
         end else if (en4) begin
            d = (div4 == 3'd0) ? 4 : int'(div4);
            for (int r = 0; r < 3; r++) begin
               for (int c = 0; c < 3; c++) begin
                  s = macc[r][c] + mp[r][c];
                  my[r][c] = (s >= d);
                  rr = (s >= d) ? s - d : s;
                  if (rr >= d) begin
                     macc[r][c] = d - 1;
                     movf = 1'b1;
                  end else begin
                     macc[r][c] = rr;
                  end
                  mp[r][c] = $countones(a4[r][c]);
               end
            end
         end
         tick();
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               exp_y[r*3 + c] = my[r][c];
            end
         end
         total++;
         if (y4 !== exp_y) begin
            bad++;
            $display("FAIL random_y cycle=%0d got=%h exp=%h", k, y4, exp_y);
         end
         total++;
         if (ovf4 !== movf) begin
            bad++;
            $display("FAIL random_ovf cycle=%0d got=%b exp=%b", k, ovf4, movf);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      en2 = 1'b0; clr2 = 1'b0; div2 = '0; a2 = '0;
      en4 = 1'b0; clr4 = 1'b0; div4 = '0; a4 = '0;
      en1 = 1'b0; clr1 = 1'b0; div1 = '0; a1 = '0;
      test_reset();
      test_full_rate();
      test_half_rate(2'd2);
      test_half_rate(2'd0);
      test_overflow();
      test_stall();
      test_one_pop();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
